// File: rtl/led_fade_pwm.sv
// -----------------------------------------------------------------------------
// led_fade_pwm
//   Turns the 1-bit light request from ToggleLight into a PWM-driven LED whose
//   brightness fades linearly. Brightness moves one level every STEP_CYCLES
//   clocks while ramping. A free-running PWM counter with a period of MAX_LEVEL
//   clocks turns the level into a duty cycle.
//
// Parameters
//   PWM_WIDTH    brightness / PWM counter width, MAX_LEVEL = 2**PWM_WIDTH-1 (>= 3)
//   STEP_CYCLES  clocks per one-level brightness step (>= 1)
//
// Ports
//   clock          in   1          system clock
//   aresetn        in   1          asynchronous active-low reset
//   toglite_state  in   1          requested light state, 1 = on (same clock domain)
//   pwm_out        out  1          registered PWM drive to the LED pin
//   level          out  PWM_WIDTH  current brightness, 0..MAX_LEVEL
//   busy           out  1          high while ramping up or down
//   debug          out  7          thermometer bar of the top 3 level bits
//
// Build option
//   DEBUG_BAR_EN  when defined, debug shows the bar graph; otherwise debug is 0
//                 and no bar-graph logic is built.
// -----------------------------------------------------------------------------
module led_fade_pwm #(
  parameter int PWM_WIDTH   = 8,
  parameter int STEP_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 aresetn,
  input  logic                 toglite_state,
  output logic                 pwm_out,
  output logic [PWM_WIDTH-1:0] level,
  output logic                 busy,
  output logic [6:0]           debug
);

  localparam logic [PWM_WIDTH-1:0] MAX_LEVEL = {PWM_WIDTH{1'b1}};
  // A single-cycle step still needs a 1-bit counter that simply stays at 0.
  localparam int                   STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_OFF  = 2'd0,
    RAMP_UP   = 2'd1,
    IDLE_ON   = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [STEP_W-1:0]    step_cnt, step_cnt_nxt;
  logic [PWM_WIDTH-1:0] level_nxt;
  logic [PWM_WIDTH-1:0] pwm_cnt;

  // Saturating level arithmetic: the level never wraps in either direction.
  function automatic logic [PWM_WIDTH-1:0] level_inc(input logic [PWM_WIDTH-1:0] l);
    return (l == MAX_LEVEL) ? l : l + 1'b1;
  endfunction

  function automatic logic [PWM_WIDTH-1:0] level_dec(input logic [PWM_WIDTH-1:0] l);
    return (l == '0) ? l : l - 1'b1;
  endfunction

  // Fade state machine: state, step counter and level are decided together.
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    level_nxt    = level;
    case (state)
      IDLE_OFF: begin
        if (toglite_state) begin
          state_nxt    = RAMP_UP;
          step_cnt_nxt = '0;
        end
      end
      IDLE_ON: begin
        if (!toglite_state) begin
          state_nxt    = RAMP_DOWN;
          step_cnt_nxt = '0;
        end
      end
      RAMP_UP: begin
        // A reversal wins over a pending step, so the level holds this cycle.
        if (!toglite_state) begin
          state_nxt    = RAMP_DOWN;
          step_cnt_nxt = '0;
        end else if (level == MAX_LEVEL) begin
          state_nxt = IDLE_ON;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_nxt = '0;
          level_nxt    = level_inc(level);
          if (level == MAX_LEVEL - 1'b1) state_nxt = IDLE_ON;
        end else begin
          step_cnt_nxt = step_cnt + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (toglite_state) begin
          state_nxt    = RAMP_UP;
          step_cnt_nxt = '0;
        end else if (level == '0) begin
          state_nxt = IDLE_OFF;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_nxt = '0;
          level_nxt    = level_dec(level);
          if (level == {{(PWM_WIDTH-1){1'b0}}, 1'b1}) state_nxt = IDLE_OFF;
        end else begin
          step_cnt_nxt = step_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE_OFF;
        step_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE_OFF;
      step_cnt <= '0;
      level    <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      level    <= level_nxt;
    end
  end

  // PWM: counter period is MAX_LEVEL, so level MAX_LEVEL is always on and
  // level L gives exactly L high cycles per period.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == MAX_LEVEL - 1'b1) ? '0 : pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < level);
    end
  end

  assign busy = (state == RAMP_UP) || (state == RAMP_DOWN);

`ifdef DEBUG_BAR_EN
  logic [2:0] level_top;
  assign level_top = level[PWM_WIDTH-1 -: 3];

  for (genvar i = 0; i < 7; i++) begin : g_bar
    assign debug[i] = (level_top > 3'(i));
  end
`else
  assign debug = 7'b0;
`endif

endmodule
